// File: rtl/button_sequencer.sv
// Synchronizes, debounces and arbitrates four push-buttons into one-hot command pulses.
// Define AUTO_REPEAT_EN to build hold-to-repeat for inc/dec; otherwise one pulse per press.
module button_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_dec,
  input  logic btn_inc,
  input  logic btn_prev,
  input  logic btn_next,
  output logic dec,
  output logic inc,
  output logic prev,
  output logic next,
  output logic busy
);

  localparam int unsigned NBTN = 4;
  localparam int unsigned MAX_CNT =
    (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
      ((DEBOUNCE_CYCLES > REPEAT_RATE) ? DEBOUNCE_CYCLES : REPEAT_RATE) :
      ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guard: all periods non-zero and counters wide enough.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      CNT_W < 1 || $clog2(MAX_CNT) > CNT_W) begin : g_bad_params
    $error("button_sequencer: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HOLD         = 2'd1,
`ifdef AUTO_REPEAT_EN
    REPEAT       = 2'd2,
`endif
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [NBTN-1:0]  sync1_q, sync1_d;
  logic [NBTN-1:0]  sync2_q, sync2_d;
  logic [NBTN-1:0]  db_q, db_d;
  logic [CNT_W-1:0] db_cnt_q [NBTN];
  logic [CNT_W-1:0] db_cnt_d [NBTN];
  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [NBTN-1:0]  cmd_q, cmd_d;
  logic             busy_q, busy_d;
  logic [1:0]       pick;
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_RATE_LD  = CNT_W'(REPEAT_RATE - 1);
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

  // Two-flop synchronizer and per-button stability counter.
  always_comb begin
    sync1_d = {btn_next, btn_prev, btn_inc, btn_dec};
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < NBTN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) db_d[i] = ~db_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Fixed priority next > prev > inc > dec.
  always_comb begin
    if      (db_q[3]) pick = 2'd3;
    else if (db_q[2]) pick = 2'd2;
    else if (db_q[1]) pick = 2'd1;
    else              pick = 2'd0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cmd_d   = '0;
`ifdef AUTO_REPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|db_q) begin
          owner_d       = pick;
          cmd_d[pick]   = 1'b1;
          state_d       = HOLD;
`ifdef AUTO_REPEAT_EN
          rpt_cnt_d     = RPT_DELAY_LD;
`endif
        end
      end
      HOLD: begin
        if (!db_q[owner_q]) begin
          state_d = RELEASE_WAIT;
        end
`ifdef AUTO_REPEAT_EN
        else if (rpt_cnt_q == '0 && !owner_q[1]) begin
          cmd_d[owner_q] = 1'b1;
          rpt_cnt_d      = RPT_RATE_LD;
          state_d        = REPEAT;
        end else if (rpt_cnt_q != '0) begin
          rpt_cnt_d = rpt_cnt_q - CNT_W'(1);
        end
`endif
      end
`ifdef AUTO_REPEAT_EN
      REPEAT: begin
        if (!db_q[owner_q]) begin
          state_d = RELEASE_WAIT;
        end else if (rpt_cnt_q == '0) begin
          cmd_d[owner_q] = 1'b1;
          rpt_cnt_d      = RPT_RATE_LD;
        end else begin
          rpt_cnt_d = rpt_cnt_q - CNT_W'(1);
        end
      end
`endif
      // Lock out buttons pressed during ownership until everything is released.
      RELEASE_WAIT: begin
        if (db_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
      state_q <= IDLE;
      owner_q <= '0;
      cmd_q   <= '0;
      busy_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q <= state_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q <= rpt_cnt_d;
`endif
    end
  end

  assign dec  = cmd_q[0];
  assign inc  = cmd_q[1];
  assign prev = cmd_q[2];
  assign next = cmd_q[3];
  assign busy = busy_q;

endmodule

// File: tb/tb_button_sequencer.sv
// Randomized scoreboard bench for button_sequencer against a behavioural command model.
module tb_button_sequencer;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic btn_dec, btn_inc, btn_prev, btn_next;
  logic dec, inc, prev, next, busy;

  button_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_dec (btn_dec),
    .btn_inc (btn_inc),
    .btn_prev(btn_prev),
    .btn_next(btn_next),
    .dec     (dec),
    .inc     (inc),
    .prev    (prev),
    .next    (next),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int cmd;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   passes;
  logic busy_exp;
  bit   mon_en;

  // Reference model state (bit 0 dec, 1 inc, 2 prev, 3 next).
  logic [3:0] m_s1, m_s2, m_db;
  int         m_run [4];
  int         m_own;
  bit         m_lock;
  int         m_hold;
  int         m_pulse;
  logic [3:0] cur_btn;
  logic       cur_rst;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endfunction

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_own = -1; m_lock = 0; m_hold = 0; m_pulse = -1;
  endfunction

  // One clock edge: commands see debounced levels from before the edge.
  function automatic void model_edge();
    m_pulse = -1;
    if (!cur_rst) begin
      model_reset();
      return;
    end
    if (m_lock) begin
      if (m_db == 4'b0) m_lock = 0;
    end else if (m_own < 0) begin
      if (m_db != 4'b0) begin
        m_own   = m_db[3] ? 3 : m_db[2] ? 2 : m_db[1] ? 1 : 0;
        m_hold  = 0;
        m_pulse = m_own;
      end
    end else if (!m_db[m_own]) begin
      m_own  = -1;
      m_lock = 1;
    end else begin
      m_hold++;
`ifdef AUTO_REPEAT_EN
      if (m_own < 2 && m_hold >= int'(RD) && (m_hold - int'(RD)) % int'(RR) == 0)
        m_pulse = m_own;
`endif
    end
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] == m_db[i]) m_run[i] = 0;
      else if (m_run[i] + 1 >= int'(DB)) begin
        m_db[i]  = ~m_db[i];
        m_run[i] = 0;
      end else m_run[i]++;
    end
    m_s2 = m_s1;
    m_s1 = cur_btn;
  endfunction

  // Advance one cycle, record expectations, then drive the next input values.
  task automatic tick(input logic [3:0] nb, input logic nr);
    @(posedge clock);
    cyc++;
    model_edge();
    #1;
    if (!nr) model_reset();
    if (m_pulse >= 0) exp_q.push_back('{cyc, m_pulse});
    busy_exp = (m_own >= 0) || m_lock;
    {btn_next, btn_prev, btn_inc, btn_dec} = nb;
    reset_n = nr;
    cur_btn = nb;
    cur_rst = nr;
  endtask

  // Monitor: compare outputs against the oldest due expectation.
  always @(negedge clock) begin
    logic [3:0] o;
    logic [3:0] exp_vec;
    exp_t       e;
    if (mon_en) begin
      o       = {next, prev, inc, dec};
      exp_vec = 4'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        exp_vec[e.cmd] = 1'b1;
      end
      check("cmd_pulse", int'(o), int'(exp_vec));
      check("onehot", int'($countones(o) <= 1), 1);
      check("busy", int'(busy), int'(busy_exp));
    end
  end

  initial begin
    logic [3:0] b;
    int         kind;
    int         len;
    int         sh;
    checks = 0; passes = 0; cyc = 0; busy_exp = 1'b0; mon_en = 0;
    cur_btn = '0; cur_rst = 1'b0;
    model_reset();
    {btn_next, btn_prev, btn_inc, btn_dec} = 4'b0;
    #1 reset_n = 1'b0;
    mon_en = 1;
    repeat (3) tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);

    // Hold inc 20 cycles, then release.
    repeat (20) tick(4'b0010, 1'b1);
    repeat (20) tick(4'b0000, 1'b1);
    // Short glitch, then a minimum-length press.
    repeat (3)  tick(4'b0010, 1'b1);
    repeat (10) tick(4'b0000, 1'b1);
    repeat (4)  tick(4'b0010, 1'b1);
    repeat (20) tick(4'b0000, 1'b1);
    // dec and next together.
    repeat (10) tick(4'b1001, 1'b1);
    repeat (20) tick(4'b0000, 1'b1);
    // next held, prev pressed during ownership.
    repeat (10) tick(4'b1000, 1'b1);
    repeat (10) tick(4'b1100, 1'b1);
    repeat (20) tick(4'b1000, 1'b1);
    repeat (20) tick(4'b0000, 1'b1);
    // Reset while inc is repeating, inc still held afterwards.
    repeat (30) tick(4'b0010, 1'b1);
    repeat (2)  tick(4'b0010, 1'b0);
    repeat (20) tick(4'b0010, 1'b1);
    repeat (20) tick(4'b0000, 1'b1);
    // Long dec hold.
    repeat (50) tick(4'b0001, 1'b1);
    repeat (20) tick(4'b0000, 1'b1);

    for (int seg = 0; seg < 150; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        b   = 4'($urandom_range(1, 15));
        len = $urandom_range(1, 3);
        repeat (len) tick(b, 1'b1);
      end else if (kind == 1) begin
        len = $urandom_range(1, 3);
        repeat (len) tick(cur_btn, 1'b0);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          sh = $urandom_range(0, 3);
          b  = 4'b0001 << sh;
        end else begin
          b = 4'($urandom_range(0, 15));
        end
        len = $urandom_range(1, 45);
        repeat (len) tick(b, 1'b1);
      end
      len = $urandom_range(0, 12);
      for (int g = 0; g < len; g++)
        tick(($urandom_range(0, 3) == 0) ? cur_btn : 4'b0000, 1'b1);
    end

    repeat (30) tick(4'b0000, 1'b1);
    @(negedge clock);
    #1;
    check("pending_expected", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
